// File: rtl/dmem_decrypt_pkg.sv
// Shared constants, state encoding and helpers for the data-memory decrypt sequencer.
package dmem_decrypt_pkg;

    localparam int unsigned ADDR_PRE  = 61;
    localparam int unsigned ADDR_TAPS = 62;
    localparam int unsigned ADDR_SEED = 63;
    localparam int unsigned CT_BASE   = 64;
    localparam int unsigned MSG_LEN   = 60;
    localparam int unsigned MAX_PRE   = 12;
    localparam logic [7:0]  PAD_CHAR  = 8'h20;

    localparam int unsigned LFSR_W = 7;
    localparam int unsigned PRE_W  = 4;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_P,
        ST_LD_T,
        ST_LD_S,
        ST_SKIP,
        ST_DEC,
        ST_PAD,
        ST_DONE
    } state_t;

    // Preamble lengths beyond the message budget saturate at MAX_PRE.
    function automatic logic [PRE_W-1:0] clamp_pre(input logic [PRE_W-1:0] p);
        return (p > PRE_W'(MAX_PRE)) ? PRE_W'(MAX_PRE) : p;
    endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR: shifts left, feedback is the parity of state & taps.
module lfsr7
    import dmem_decrypt_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] taps,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    // load wins over adv so a reload never races an advance.
    always_ff @(posedge clk) begin
        if (load) begin
            state <= seed;
        end else if (adv) begin
            state <= {state[LFSR_W-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/dmem_decrypt.sv
// Decrypts the LFSR-encrypted message in dmem[64:123] into dmem[0:59], dropping the
// preamble and padding the tail with spaces.
module dmem_decrypt
    import dmem_decrypt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] raddr,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             wen,
    output logic             busy,
    output logic             done
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PRE_W-1:0]  pre, pre_next;
    logic [LFSR_W-1:0] taps, taps_next;
    logic [LFSR_W-1:0] lfsr_state, lfsr_seed;
    logic              lfsr_load, lfsr_adv, wen_fsm;
    logic              pre_last, dec_last;
    logic              unused_rdata;

    assign unused_rdata = ^rdata[WIDTH-1:LFSR_W];

    assign pre_last = (32'(cnt) + 32'd1 == 32'(pre));
    assign dec_last = (32'(cnt) + 32'(pre) + 32'd1 == MSG_LEN);

    // Reset zeroes the LFSR through its load path.
    assign lfsr_seed = init ? '0 : rdata[LFSR_W-1:0];

    lfsr7 u_lfsr (
        .clk   (clk),
        .load  (init | lfsr_load),
        .seed  (lfsr_seed),
        .taps  (taps),
        .adv   (lfsr_adv),
        .state (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (init) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pre   <= '0;
            taps  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pre   <= pre_next;
            taps  <= taps_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pre_next   = pre;
        taps_next  = taps;
        raddr      = '0;
        waddr      = '0;
        wdata      = '0;
        wen_fsm    = 1'b0;
        done       = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LD_P;
            end
            ST_LD_P: begin
                raddr      = WIDTH'(ADDR_PRE);
                pre_next   = clamp_pre(rdata[PRE_W-1:0]);
                state_next = ST_LD_T;
            end
            ST_LD_T: begin
                raddr      = WIDTH'(ADDR_TAPS);
                taps_next  = rdata[LFSR_W-1:0];
                state_next = ST_LD_S;
            end
            ST_LD_S: begin
                raddr      = WIDTH'(ADDR_SEED);
                lfsr_load  = 1'b1;
                cnt_next   = '0;
                state_next = (pre == '0) ? ST_DEC : ST_SKIP;
            end
            ST_SKIP: begin
                lfsr_adv = 1'b1;
                if (pre_last) begin
                    cnt_next   = '0;
                    state_next = ST_DEC;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DEC: begin
                raddr    = WIDTH'(CT_BASE + 32'(pre) + 32'(cnt));
                waddr    = WIDTH'(cnt);
                wdata    = WIDTH'({1'b0, rdata[LFSR_W-1:0] ^ lfsr_state});
                wen_fsm  = 1'b1;
                lfsr_adv = 1'b1;
                if (dec_last) begin
                    cnt_next   = '0;
                    state_next = (pre == '0) ? ST_DONE : ST_PAD;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_PAD: begin
                waddr   = WIDTH'(MSG_LEN - 32'(pre) + 32'(cnt));
                wdata   = WIDTH'(PAD_CHAR);
                wen_fsm = 1'b1;
                if (pre_last) begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A reset cycle must never commit a write, even mid-pass.
    assign wen  = wen_fsm & ~init;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_decrypt.sv
// Bench for dmem_decrypt: behavioural memory plus a software decrypt reference.
module tb_dmem_decrypt;

    logic       clk = 1'b0;
    logic       init, start;
    logic [7:0] rdata, raddr, waddr, wdata;
    logic       wen, busy, done;

    logic [7:0] mem  [0:255];
    logic [7:0] snap [0:255];
    logic [7:0] expm [0:255];
    logic [7:0] msg  [0:47];

    int checks = 0;
    int errors = 0;
    int nwr, bad_wr, dones, cyc, p;

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

    dmem_decrypt #(.WIDTH(8)) dut (
        .clk   (clk),
        .init  (init),
        .start (start),
        .rdata (rdata),
        .raddr (raddr),
        .waddr (waddr),
        .wdata (wdata),
        .wen   (wen),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record the write/done visible now, commit the write after the edge.
    task automatic step();
        logic       w;
        logic [7:0] wa, wd;
        w  = wen;
        wa = waddr;
        wd = wdata;
        if (w === 1'b1) begin
            if (int'(wa) != nwr || wa >= 8'd60) bad_wr++;
            nwr++;
        end
        if (done === 1'b1) dones++;
        @(posedge clk);
        #1;
        if (w === 1'b1) mem[wa] = wd;
        @(negedge clk);
    endtask

    task automatic fill_random(input logic [7:0] pv, input logic [7:0] tv, input logic [7:0] sv);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[61] = pv;
        mem[62] = tv;
        mem[63] = sv;
    endtask

    // Reference: clamp P, walk the keystream from S0, keep bytes past the preamble, pad.
    task automatic expect_model();
        int         pp;
        logic [6:0] s, t;
        for (int i = 0; i < 256; i++) expm[i] = snap[i];
        pp = int'(snap[61][3:0]);
        if (pp > 12) pp = 12;
        t = snap[62][6:0];
        s = snap[63][6:0];
        for (int i = 0; i < 60; i++) begin
            if (i >= pp) expm[i - pp] = {1'b0, snap[64 + i][6:0] ^ s};
            s = {s[5:0], ^(s & t)};
        end
        for (int j = 0; j < pp; j++) expm[60 - pp + j] = 8'h20;
    endtask

    task automatic check_region(input string tag);
        for (int i = 0; i < 128; i++)
            chk($sformatf("%s mem[%0d]", tag, i), 32'(mem[i]), 32'(expm[i]));
    endtask

    task automatic run_pass(input int restart_at, input int abort_at, output int ncyc);
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        nwr    = 0;
        bad_wr = 0;
        dones  = 0;
        start  = 1'b1;
        step();
        start = 1'b0;
        ncyc  = 1;
        while (done !== 1'b1 && ncyc < 200) begin
            start = (ncyc == restart_at);
            if (ncyc == abort_at) begin
                chk("abort_wen_before", 32'(wen), 32'd1);
                chk("abort_waddr", 32'(waddr), 32'd10);
                init = 1'b1;
                #1;
                chk("abort_wen_gated", 32'(wen), 32'd0);
                step();
                init  = 1'b0;
                start = 1'b0;
                chk("abort_idle", 32'(busy), 32'd0);
                return;
            end
            step();
            ncyc++;
        end
        start = 1'b0;
        if (done === 1'b1) step();
    endtask

    initial begin
        init  = 1'b1;
        start = 1'b0;
        fill_random(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        init = 1'b0;
        @(negedge clk);

        // Directed P=0 vector
        fill_random(8'h00, 8'h60, 8'h01);
        mem[64] = 8'h40;
        mem[65] = 8'h43;
        run_pass(-1, -1, cyc);
        expect_model();
        chk("p0_cycles", 32'(cyc), 32'd64);
        chk("p0_mem0", 32'(mem[0]), 32'h41);
        chk("p0_mem1", 32'(mem[1]), 32'h41);
        chk("p0_writes", 32'(nwr), 32'd60);
        chk("p0_bad_wr", 32'(bad_wr), 32'd0);
        chk("p0_dones", 32'(dones), 32'd1);
        check_region("p0");

        // P=12 with a message encrypted forward by the bench
        fill_random(8'h0C, 8'h60, 8'h01);
        for (int k = 0; k < 48; k++) msg[k] = 8'($urandom_range(32, 126));
        begin
            logic [6:0] s;
            s = 7'h01;
            for (int i = 0; i < 60; i++) begin
                if (i >= 12) mem[64 + i] = {1'($urandom), msg[i - 12][6:0] ^ s};
                s = {s[5:0], ^(s & 7'h60)};
            end
        end
        run_pass(-1, -1, cyc);
        chk("p12_cycles", 32'(cyc), 32'd76);
        chk("p12_writes", 32'(nwr), 32'd60);
        for (int k = 0; k < 48; k++) chk($sformatf("p12 msg[%0d]", k), 32'(mem[k]), 32'(msg[k]));
        for (int k = 48; k < 60; k++) chk($sformatf("p12 pad[%0d]", k), 32'(mem[k]), 32'h20);
        for (int k = 60; k < 128; k++) chk($sformatf("p12 keep[%0d]", k), 32'(mem[k]), 32'(snap[k]));

        // P field 0x0F clamps to 12
        fill_random(8'h0F, 8'($urandom), 8'($urandom));
        run_pass(-1, -1, cyc);
        expect_model();
        chk("pF_cycles", 32'(cyc), 32'd76);
        chk("pF_writes", 32'(nwr), 32'd60);
        chk("pF_bad_wr", 32'(bad_wr), 32'd0);
        check_region("pF");

        // Ciphertext bit 7 ignored
        fill_random(8'h00, 8'($urandom), 8'h01);
        mem[64] = 8'hC0;
        run_pass(-1, -1, cyc);
        chk("bit7_mem0", 32'(mem[0]), 32'h41);

        // Random passes
        for (int r = 0; r < 5; r++) begin
            fill_random(8'($urandom), 8'($urandom), 8'($urandom));
            run_pass(-1, -1, cyc);
            expect_model();
            p = int'(snap[61][3:0]);
            if (p > 12) p = 12;
            chk($sformatf("rnd%0d_cycles", r), 32'(cyc), 32'(64 + p));
            chk($sformatf("rnd%0d_writes", r), 32'(nwr), 32'd60);
            chk($sformatf("rnd%0d_bad_wr", r), 32'(bad_wr), 32'd0);
            chk($sformatf("rnd%0d_dones", r), 32'(dones), 32'd1);
            check_region($sformatf("rnd%0d", r));
        end

        // Reset during DEC cycle 10 (P=3: DEC starts at cycle 7)
        fill_random(8'h03, 8'($urandom), 8'($urandom));
        run_pass(-1, 17, cyc);
        repeat (5) step();
        expect_model();
        for (int i = 10; i < 60; i++) expm[i] = snap[i];
        chk("abort_writes", 32'(nwr), 32'd10);
        chk("abort_bad_wr", 32'(bad_wr), 32'd0);
        chk("abort_dones", 32'(dones), 32'd0);
        check_region("abort");

        // start during DEC ignored; T=0, S0=0 passes ciphertext through with bit 7 cleared
        fill_random(8'h05, 8'h00, 8'h00);
        run_pass(20, -1, cyc);
        chk("rs_cycles", 32'(cyc), 32'd69);
        repeat (80) step();
        expect_model();
        chk("rs_dones", 32'(dones), 32'd1);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_mem0", 32'(mem[0]), 32'({1'b0, snap[69][6:0]}));
        check_region("rs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_decrypt.md
# dmem_decrypt

Sequencer that decrypts the LFSR-encrypted message held in data memory and writes the recovered plaintext back into the message region. It drives the read and write ports of `dmem`: it loads the preamble length, tap pattern and LFSR start state, regenerates the keystream, and discards the preamble. It then writes the decrypted payload followed by space padding. It is the receive/decode end of the encrypt path that fills `mem[64:123]`.

## Interface
- `WIDTH`, 8: data and address width; must match `dmem`.
- `clk`  in  1: rising-edge clock.
- `init`  in  1: synchronous, active-high reset.
- `start`  in  1: begin one decrypt pass; sampled only in IDLE.
- `rdata`  in  WIDTH: `dmem.data_o`; combinational read of `raddr` in the same cycle.
- `raddr`  out  WIDTH: to `dmem.raddr`.
- `waddr`  out  WIDTH: to `dmem.waddr`.
- `wdata`  out  WIDTH: to `dmem.data_i`.
- `wen`  out  1: to `dmem.wen`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the pass completes.

## Operation
- Memory map:
  - `mem[61]` = preamble length P. Use bits [3:0]; clamp values above 12 to 12.
  - `mem[62]` = taps T, bits [6:0].
  - `mem[63]` = start state S0, bits [6:0].
  - `mem[64:123]` = 60 ciphertext bytes.
  - Plaintext region is `mem[0:59]`.
- LFSR (7-bit): next = {s[5:0], ^(s & T)}.
  - Ciphertext byte i (address 64+i) was encrypted with state s_i, where s_0 = S0.
  - T = 0 or S0 = 0 is legal; the arithmetic is applied unchanged, with no special case.
- Decrypt: plaintext = {1'b0, c[6:0] ^ s_i}. Ciphertext bit 7 is ignored.
- States:
  - IDLE: wait for `start`.
  - LD_P: `raddr`=61; latch the clamped P.
  - LD_T: `raddr`=62; latch T.
  - LD_S: `raddr`=63; latch S0 into the LFSR.
  - SKIP: P cycles; advance the LFSR each cycle; no reads, no writes. Bypassed when P=0.
  - DEC: 60-P cycles. On cycle k:
    - `raddr`=64+P+k, `waddr`=k, `wen`=1, `wdata`=decrypted byte.
    - Advance the LFSR.
  - PAD: P cycles. On cycle j: `waddr`=60-P+j, `wdata`=8'h20, `wen`=1.
  - DONE: `done`=1 for one cycle; then IDLE.
- Addresses 60..127 are never written. Parameters and ciphertext survive the pass.
- `start` while `busy` is ignored. `start` held high in IDLE after DONE launches a new pass.

## Timing
- Reset values: `raddr`=0, `waddr`=0, `wdata`=0, `wen`=0, `busy`=0, `done`=0. State = IDLE, LFSR = 0.
- `init` overrides everything:
  - `wen` is gated to 0 combinationally in any cycle where `init`=1, so a mid-pass reset causes no stray write.
  - State returns to IDLE on the next edge.
- Pass length: `start` sampled at edge 0, then 3 load cycles + P + (60-P) + P + 1 = 64+P cycles until `done`.
  - P=0: 64 cycles. P=12: 76 cycles.
- Reads are same-cycle. In DEC, `wdata` is a combinational function of `rdata` and the current LFSR state.
- The LFSR, P, T and the counters update on the rising edge only.

## Structure
- Package `dmem_decrypt_pkg` holds:
  - Constants: `ADDR_PRE`=61, `ADDR_TAPS`=62, `ADDR_SEED`=63, `CT_BASE`=64, `MSG_LEN`=60, `MAX_PRE`=12, `PAD_CHAR`=8'h20.
  - The state enum.
- Sub-module `lfsr7`: ports `clk`, `load`, `seed[6:0]`, `taps[6:0]`, `adv`, `state[6:0]`.
  - `load` has priority over `adv`.
- Top level contains the FSM and a 6-bit position counter shared by SKIP, DEC and PAD.

## Test plan
- P=0, T=7'h60, S0=7'h01, `mem[64]`=8'h40, `mem[65]`=8'h43 -> `mem[0]`=8'h41, `mem[1]`=8'h41 (s_1=7'h02); `done` at cycle 64.
- P=12, T=7'h60, S0=7'h01:
  - 48-char message pre-encrypted by a reference model -> `mem[0:47]` = message, `mem[48:59]` = 8'h20.
  - `mem[60:127]` unchanged; `done` at cycle 76.
- P field 8'h0F -> treated as 12: exactly 48 DEC writes and 12 PAD writes.
- Ciphertext with bit 7 set, e.g. 8'hC0 with s=7'h01 -> writes 8'h41.
- `init` asserted at DEC cycle 10 -> `wen`=0 in that cycle; IDLE on next edge; `mem[10:59]` untouched.
- `start` pulsed during DEC -> ignored; exactly one `done`. T=0, S0=0 -> plaintext equals ciphertext with bit 7 cleared.
